// File: rtl/bus_change_monitor_pkg.sv
// Shared types and default sizes for the bus change monitor and its event FIFO.
package bus_change_monitor_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;
  localparam int TS_W_DEF   = 32;

  typedef struct packed {
    logic [TS_W_DEF-1:0]   ts;
    logic [DATA_W_DEF-1:0] prev;
    logic [DATA_W_DEF-1:0] data;
  } event_t;

endpackage

// File: rtl/bus_change_monitor_if.sv
// Monitored bus plus the change-event read port of bus_change_monitor.
interface bus_change_monitor_if
  import bus_change_monitor_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
);

  logic [DATA_W-1:0]          bus_data;
  // Read port: an event transfers on a posedge where out_valid && out_ready;
  // while out_valid=1 and out_ready=0 every out_* field holds its value.
  logic                       out_valid;
  logic                       out_ready;
  logic [TS_W-1:0]            out_ts;
  logic [DATA_W-1:0]          out_prev;
  logic [DATA_W-1:0]          out_data;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       overflow;

  modport master (
    output bus_data, out_ready,
    input  out_valid, out_ts, out_prev, out_data, count, overflow
  );

  modport slave (
    input  bus_data, out_ready,
    output out_valid, out_ts, out_prev, out_data, count, overflow
  );

endinterface

// File: rtl/bus_change_fifo.sv
// DEPTH-entry synchronous FIFO of change events; optional overwrite-oldest on full push.
module bus_change_fifo
  import bus_change_monitor_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEF,
  parameter type entry_t = event_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       drop_oldest,
  input  entry_t                     wdata,
  output entry_t                     head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          full_no_pop;
  logic          do_write;
  logic          adv_rd;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign head   = empty ? '0 : mem[rd_ptr];

  // A full push only lands when a pop frees a slot or the oldest entry is sacrificed.
  assign do_pop      = pop && !empty;
  assign full_no_pop = full && !do_pop;
  assign do_write    = push && (!full_no_pop || drop_oldest);
  assign adv_rd      = do_pop || (push && full_no_pop && drop_oldest);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_write) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (adv_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_write && !adv_rd)      count <= count + CW'(1);
      else if (adv_rd && !do_write) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/bus_change_monitor.sv
// Samples a shared bus each cycle and logs value changes as timestamped events.
// Build option: BUS_CHANGE_MONITOR_DROP_OLDEST_EN overwrites the oldest event when full.
module bus_change_monitor
  import bus_change_monitor_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TS_W   = TS_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  bus_change_monitor_if.slave mon
);

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] data;
  } mon_event_t;

`ifdef BUS_CHANGE_MONITOR_DROP_OLDEST_EN
  localparam logic DROP_OLDEST = 1'b1;
`else
  localparam logic DROP_OLDEST = 1'b0;
`endif

  logic [TS_W-1:0]            cyc_cnt;
  logic [DATA_W-1:0]          prev_q;
  logic                       primed;
  logic                       overflow_q;
  logic                       change;
  logic                       pop;
  logic                       full;
  logic                       empty;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  mon_event_t                 new_event;
  mon_event_t                 head;

  // The first sample after reset only establishes the baseline.
  assign change    = primed && (mon.bus_data != prev_q);
  assign new_event = '{ts: cyc_cnt, prev: prev_q, data: mon.bus_data};
  assign pop       = mon.out_valid && mon.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt    <= '0;
      prev_q     <= '0;
      primed     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt + TS_W'(1);
      prev_q  <= mon.bus_data;
      primed  <= 1'b1;
      if (change && full && !pop) overflow_q <= 1'b1;
    end
  end

  bus_change_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (mon_event_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (change),
    .pop         (pop),
    .drop_oldest (DROP_OLDEST),
    .wdata       (new_event),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .count       (fifo_count)
  );

  assign mon.out_valid = !empty;
  assign mon.out_ts    = head.ts;
  assign mon.out_prev  = head.prev;
  assign mon.out_data  = head.data;
  assign mon.count     = fifo_count;
  assign mon.overflow  = overflow_q;

endmodule

// File: tb/tb_bus_change_monitor.sv
// Randomized and directed bench for bus_change_monitor against a queue-based change-log model.
module tb_bus_change_monitor;

  localparam int DW    = 16;
  localparam int TW    = 32;
  localparam int DEPTH = 4;
  localparam int EW    = TW + 2*DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_change_monitor_if #(.DATA_W(DW), .TS_W(TW), .DEPTH(DEPTH)) bif ();

  bus_change_monitor #(.DATA_W(DW), .DEPTH(DEPTH), .TS_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bif.slave)
  );

  // reference model: the change log as a bounded queue of {ts, prev, data}
  logic [EW-1:0] exp_q[$];
  logic [TW-1:0] m_cyc;
  logic [DW-1:0] m_prev;
  logic          m_primed;
  logic          m_ovf;
  logic          checking = 1'b0;
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] cur_bus = '0;

  task automatic model_edge(input logic [DW-1:0] b, input logic r, input logic rs);
    logic [EW-1:0] ev;
    if (rs) begin
      exp_q.delete();
      m_cyc = '0; m_prev = '0; m_primed = 1'b0; m_ovf = 1'b0;
    end else begin
      if (r && exp_q.size() > 0) exp_q.delete(0);
      if (m_primed && b != m_prev) begin
        ev = {m_cyc, m_prev, b};
        if (exp_q.size() < DEPTH) exp_q.push_back(ev);
        else begin
          m_ovf = 1'b1;
`ifdef BUS_CHANGE_MONITOR_DROP_OLDEST_EN
          exp_q.delete(0);
          exp_q.push_back(ev);
`endif
        end
      end
      m_prev = b; m_primed = 1'b1; m_cyc = m_cyc + 1;
    end
  endtask

  // driver: apply inputs, let one posedge pass, then advance the model
  task automatic cycle(input logic [DW-1:0] b, input logic r, input logic rs);
    bif.bus_data  = b;
    bif.out_ready = r;
    rst           = rs;
    cur_bus       = b;
    @(posedge clk);
    #1;
    model_edge(b, r, rs);
  endtask

  task automatic hold(input logic [DW-1:0] b, input logic r, input int n);
    for (int i = 0; i < n; i++) cycle(b, r, 1'b0);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // scoreboard monitor: compares the presented head and status every cycle
  always @(negedge clk) begin
    if (checking) begin
      check("count", 64'(bif.count), 64'(exp_q.size()));
      check("overflow", 64'(bif.overflow), 64'(m_ovf));
      check("out_valid", 64'(bif.out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() == 0) begin
        check("empty_fields", {bif.out_ts, bif.out_prev, bif.out_data}, 64'd0);
      end else begin
        check("out_ts", 64'(bif.out_ts), 64'(exp_q[0][EW-1 -: TW]));
        check("out_prev", 64'(bif.out_prev), 64'(exp_q[0][2*DW-1 -: DW]));
        check("out_data", 64'(bif.out_data), 64'(exp_q[0][DW-1:0]));
      end
    end
  end

  initial begin
    bif.bus_data  = '0;
    bif.out_ready = 1'b0;
    cycle(16'h0000, 1'b0, 1'b1);
    checking = 1'b1;

    // baseline: steady bus never logs
    hold(16'h0000, 1'b0, 10);

    // single change sampled at cycle 5, then drained
    cycle(16'h0000, 1'b0, 1'b1);
    hold(16'h0000, 1'b0, 5);
    cycle(16'hdead, 1'b0, 1'b0);
    hold(16'hdead, 1'b0, 2);
    hold(16'hdead, 1'b1, 2);

    // back-to-back changes, stalled, then drained
    cycle(16'h0000, 1'b0, 1'b1);
    cycle(16'h0000, 1'b0, 1'b0);
    cycle(16'hdead, 1'b0, 1'b0);
    cycle(16'hbeef, 1'b0, 1'b0);
    hold(16'hbeef, 1'b0, 3);
    hold(16'hbeef, 1'b1, 3);

    // overflow with no pops, then drained
    cycle(16'h0000, 1'b0, 1'b1);
    cycle(16'h0000, 1'b0, 1'b0);
    for (int v = 1; v <= 5; v++) cycle(DW'(v), 1'b0, 1'b0);
    hold(16'h0005, 1'b0, 3);
    hold(16'h0005, 1'b1, 5);

    // full with simultaneous push and pop
    for (int v = 1; v <= 4; v++) cycle(DW'(v), 1'b0, 1'b0);
    for (int v = 9; v <= 12; v++) cycle(DW'(v), 1'b1, 1'b0);
    hold(16'h000c, 1'b1, 5);

    // reset mid-operation, then baseline at beef, then a change to cafe
    cycle(16'h0000, 1'b0, 1'b1);
    cycle(16'h0000, 1'b0, 1'b0);
    for (int v = 1; v <= 3; v++) cycle(DW'(v), 1'b0, 1'b0);
    cycle(16'hbeef, 1'b0, 1'b1);
    hold(16'hbeef, 1'b0, 4);
    cycle(16'hcafe, 1'b0, 1'b0);
    hold(16'hcafe, 1'b0, 2);
    hold(16'hcafe, 1'b1, 2);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] b;
      b = ($urandom_range(0, 2) == 0) ? cur_bus : DW'($urandom_range(0, 7));
      cycle(b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 149) == 0));
    end
    hold(cur_bus, 1'b1, 6);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_change_monitor.md
Name: bus_change_monitor

Overview:
- Receive-side observer for a 16-bit shared data bus that a producer drives, for example through a virtual interface handle.
- Samples the bus every clk edge and detects value changes.
- Queues each change as an event {timestamp, previous value, new value} in a small FIFO.
- Exposes the queue through a valid/ready read port, so benches and checkers can consume a cycle-accurate change log.

Parameters:
- DATA_W, 16, width of the monitored bus.
- DEPTH, 4, event FIFO entries; power of two, at least 2.
- TS_W, 32, width of the free-running cycle timestamp.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- bus_data  input  DATA_W  monitored bus value.
- out_valid  output  1  FIFO head holds an event.
- out_ready  input  1  consumer accepts the head event.
- out_ts  output  TS_W  cycle count at which the change was sampled.
- out_prev  output  DATA_W  bus value before the change.
- out_data  output  DATA_W  bus value after the change.
- count  output  $clog2(DEPTH+1)  number of occupied entries.
- overflow  output  1  sticky flag: at least one event was lost.

Behaviour:
- Reset (rst=1 at a posedge):
  - cyc_cnt=0, prev_q=0, primed=0.
  - FIFO empty, so out_valid=0 and count=0; overflow=0.
  - out_ts, out_prev and out_data are 0 while empty.
- cyc_cnt increments by 1 every non-reset cycle and wraps modulo 2^TS_W with no flag.
- Sampling:
  - Every non-reset posedge: prev_q <= bus_data, primed <= 1.
  - The first sample after reset (primed=0) is the baseline only; it never creates an event.
- Change detection:
  - When primed=1 and bus_data != prev_q (2-state compare), generate event {ts=cyc_cnt, prev=prev_q, data=bus_data}.
  - prev_q updates whether or not the event is stored.
- Latency: an event sampled at edge N is visible on out_* with out_valid=1 after edge N, i.e. in cycle N+1.
- Read port:
  - Head fields are driven from registered storage.
  - Pop occurs when out_valid && out_ready at a posedge.
  - out_* must hold stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: both take effect and count is unchanged; this applies when full too, with no overflow.
- Empty with a push in the same cycle: no bypass; the event appears next cycle.
- Full, push, no pop: handled by the overflow policy (see Optional Feature); overflow <= 1, sticky until rst.
- count stays in range 0..DEPTH; pointers wrap modulo DEPTH.
- Reset mid-operation discards all queued events and re-arms the baseline; the first post-reset sample never produces an event.

Optional Feature:
- Macro: BUS_CHANGE_MONITOR_DROP_OLDEST_EN.
- Defined: on full push without pop, the oldest entry is overwritten. The read pointer advances, the new event is stored, count stays DEPTH, and the head becomes the second-oldest event.
- Undefined (default): the new event is discarded and FIFO contents are unchanged.
- overflow sets in both builds.

Decomposition:
- Package bus_change_monitor_pkg holds:
  - the event struct typedef (ts, prev, data), parameterised via the package's default widths;
  - the localparams DATA_W_DEF=16, DEPTH_DEF=4, TS_W_DEF=32.
- One sub-module, bus_change_fifo:
  - a DEPTH-entry synchronous FIFO of event structs, with push, pop, full, empty, count and the drop-oldest mode input;
  - the top instantiates it and owns the sampling, timestamp and overflow logic.

Test Plan:
- Baseline: release rst with bus_data=16'h0000 held -> out_valid stays 0 for 10 cycles; count=0; overflow=0.
- Single change: bus steady 16'h0000, then 16'hdead sampled at cyc_cnt=5 -> in the next cycle out_valid=1, out_ts=5, out_prev=16'h0000, out_data=16'hdead. Pop with out_ready=1 -> count 0.
- Back-to-back changes: dead at ts=1, beef at ts=2, out_ready=0 -> count=2. Pop order is {1,0000,dead} then {2,dead,beef}; fields stay stable while stalled.
- Overflow, default build, DEPTH=4, no pops: bus toggles 0001..0005 on consecutive cycles -> count=4; entries hold 0001..0004; overflow=1.
- Overflow, drop-oldest build, same stimulus -> entries hold 0002..0005; head out_prev=0001, out_data=0002; overflow=1.
- Reset mid-operation: 3 events queued, then rst pulse, then bus held at 16'hbeef -> count=0, overflow=0, no event from the first post-reset sample. A later change to 16'hcafe gives out_prev=beef, out_ts equal to its post-reset cycle count.
